// File: rtl/led_bank_scheduler.sv
// Round-robin time-sharing of an LED bank between NREQ requesters.
// Each grant holds the latched pattern for max(hold,1) prescaled ticks; outputs are registered.
module led_bank_scheduler #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned NLED     = 5,
  parameter int unsigned PRESCALE = 12000
) (
  input  logic                 clki,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NLED-1:0] pattern,
  input  logic [NREQ*8-1:0]    hold,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NLED-1:0]      led,
  output logic                 busy
);

  localparam int unsigned PtrW  = $clog2(NREQ);
  localparam int unsigned PresW = $clog2(PRESCALE);

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   cur_q, cur_d;
  logic [PresW-1:0]  presc_q, presc_d;
  logic [7:0]        remain_q, remain_d;
  logic [NLED-1:0]   pat_q, pat_d;
  logic [NREQ-1:0]   fin_q, fin_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NLED-1:0]   led_q, led_d;
  logic              busy_q, busy_d;

  logic [PtrW-1:0]   sel;
  logic              found;
  logic [7:0]        hold_sel;
  logic [PtrW-1:0]   next_ptr;
  logic              tick;

  // First requesting index scanning upward from rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PtrW'(idx);
      end
    end
  end

  assign hold_sel = hold[sel*8 +: 8];
  assign next_ptr = (cur_q == PtrW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
  assign tick     = (presc_q == PresW'(PRESCALE - 1));

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_d    = cur_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    pat_d    = pat_q;
    fin_d    = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          cur_d    = sel;
          pat_d    = pattern[sel*NLED +: NLED];
          remain_d = (hold_sel == 8'd0) ? 8'd1 : hold_sel;
          presc_d  = '0;
          state_d  = StShow;
        end
      end
      StShow: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) remain_d = remain_q - 8'd1;
        // Completion takes priority over an abort in the same cycle.
        if (tick && remain_q == 8'd1) begin
          state_d       = StIdle;
          fin_d[cur_q]  = 1'b1;
          rr_ptr_d      = next_ptr;
        end else if (!req[cur_q]) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output stage lags the state register by one cycle.
  always_comb begin
    gnt_d  = '0;
    led_d  = '0;
    busy_d = 1'b0;
    done_d = fin_q;
    if (state_q == StShow) begin
      gnt_d[cur_q] = 1'b1;
      led_d        = pat_q;
      busy_d       = 1'b1;
    end
  end

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cur_q    <= '0;
      presc_q  <= '0;
      remain_q <= '0;
      pat_q    <= '0;
      fin_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_q    <= cur_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      pat_q    <= pat_d;
      fin_q    <= fin_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: doc/led_bank_scheduler.md
# led_bank_scheduler

Time-shares the board LED bank between several requesters (status monitors, heartbeat, error reporter) so that only one pattern drives the LEDs at a time. Each requester presents a pattern and a hold time. A round-robin arbiter grants the bank, and a prescaled hold counter keeps the pattern on the LEDs for exactly the requested time. The block sits between the requester logic and the top-level LED outputs in the blinky-class designs.

## Interface
- NREQ, 3: number of requesters; legal range 2..4.
- NLED, 5: width of the LED bank.
- PRESCALE, 12000: clock cycles per hold unit ("tick"); must be ≥ 2.
- clki  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  reset; asynchronous assert, active-low.
- req  input  NREQ  per-requester request level.
- pattern  input  NREQ*NLED  requester i's pattern is bits [i*NLED +: NLED].
- hold  input  NREQ*8  requester i's hold time in ticks is bits [i*8 +: 8].
- gnt  output  NREQ  one-hot grant; all zero when idle.
- done  output  NREQ  one-cycle pulse when requester i's hold completes normally.
- led  output  NLED  LED drive; registered.
- busy  output  1  high while in SHOW.

## Operation
- State machine has two states, IDLE and SHOW.
- Internal registers:
  - rr_ptr, the round-robin start index (width clog2(NREQ)).
  - cur, the granted index.
  - presc, the prescaler (0..PRESCALE-1).
  - remain, 8 bits of remaining ticks.
  - Latched pattern.
- Reset: state IDLE; rr_ptr=0, cur=0, presc=0, remain=0; gnt=0, done=0, led=0, busy=0.
- IDLE:
  - If any req bit is high, select the first set bit scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - Latch that requester's pattern and hold. A hold of 0 is treated as 1.
  - Clear presc and go to SHOW.
  - On the next edge, gnt is one-hot at cur, led shows the latched pattern, and busy=1.
  - done is 0 in every cycle except the completion pulse.
- SHOW:
  - presc increments each cycle and wraps to 0 after PRESCALE-1.
  - The wrap is a tick, and each tick decrements remain.
  - Normal completion is a tick with remain==1. On the next edge:
    - state goes to IDLE;
    - gnt=0, led=0, busy=0;
    - done[cur]=1 for one cycle;
    - rr_ptr=(cur+1) mod NREQ.
  - Abort happens when req[cur] is sampled low in SHOW. On the next edge the block takes the same transition as completion, but done stays 0 and rr_ptr still advances.
  - If a tick with remain==1 coincides with req[cur] low, completion wins and done pulses.
  - Changes to pattern or hold while granted are ignored, because both values were latched at grant.
  - Requests from other requesters are not evaluated in SHOW. There is no preemption.
- Arithmetic: remain is an unsigned 8-bit value. The maximum hold is 255 ticks. remain never wraps below 1 in SHOW.

## Timing
- Grant latency: req sampled high at edge N in IDLE produces gnt, led and busy valid after edge N+1.
- Hold duration: led holds the pattern for exactly H*PRESCALE cycles, where H=max(hold,1). These are the cycles following edges N+1 .. N+H*PRESCALE.
- Completion: done pulses and gnt/led/busy clear after edge N+1+H*PRESCALE.
- IDLE gap: IDLE lasts at least one cycle between grants. The arbitration that happens in the done cycle gives the next gnt after edge N+2+H*PRESCALE.
- A requester that keeps req high after done is re-granted only when no other requester is pending, because of the round-robin rule.
- Reset mid-operation: resetn low clears all outputs immediately without waiting for a clock. No done pulse is generated. After release, arbitration starts from requester 0.

## Test plan
All scenarios use NREQ=3, NLED=5, PRESCALE=4.
- Reset check: hold resetn low with random req → gnt=000, done=000, led=00000, busy=0 throughout reset.
- Single request: req=001, pattern0=10101, hold0=3, sampled at edge 10 → gnt=001 and led=10101 after edges 11..22 (12 cycles). After edge 23, done=001 for one cycle with led=00000 and gnt=000.
- Round-robin: req=111 held, all holds=1, distinct patterns → grant order 0,1,2,0,1. Each grant lasts 4 cycles, grants are separated by one idle cycle, and done pulses once per grant in matching order.
- Abort: req1 alone with hold=5, req1 dropped 6 cycles after grant → gnt=000 and led=00000 one edge later, done never pulses, and the next grant with req=111 goes to requester 2.
- Hold zero plus latching: hold0=0, pattern0 changed mid-show → led shows the originally latched pattern for exactly 4 cycles, then done[0] pulses.
- Async reset mid-SHOW: assert resetn low 2 cycles into a hold=10 grant → led, gnt and busy are 0 immediately (before the next clki edge) with no done. After release with req=110, requester 1 is granted.
